mem_access_unit: RTL

//  Pipeline-side initiator for the word-wide data RAM (dm_* interface).
//  - Turns MIPS load/store requests (LB/LBU/LH/LHU/LW/SB/SH/SW) on byte addresses into word accesses.
//  - Does sign/zero extension for loads.
//  - Does sub-word stores as read-modify-write, because the RAM writes whole words only.
//  - Sits between the MEM stage and the RAM. Stalls the pipeline through a valid/ready handshake.

---
 rtl/mem_access_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
// Load/store initiator for the word-wide data RAM: lane select, extension,
// and read-modify-write for sub-word stores behind a valid/ready handshake.
module mem_access_unit #(
    parameter int DATA_SIZE  = 32,
    parameter int SELEC_SIZE = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_misaligned,
    output logic                  dm_we,
    output logic [SELEC_SIZE-1:0] dm_address,
    output logic [DATA_SIZE-1:0]  dm_d,
    input  logic [DATA_SIZE-1:0]  dm_q
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_RMW   = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam int AW = SELEC_SIZE + 2;

    logic [2:0]           state_q, state_d;
    logic [1:0]           size_q, size_d;
    logic                 uns_q, uns_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
    logic                 mis_q, mis_d;
    logic [31:0]          rdata_q, rdata_d;
    logic [DATA_SIZE-1:0] merge_q, merge_d;

    logic                 accept;
    logic                 req_mis;
    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;
    logic [31:0]          load_val;
    logic [DATA_SIZE-1:0] merge_val;

    assign accept = req_valid && (state_q == S_IDLE);

    always_comb begin
        req_mis = 1'b0;
        case (req_size)
            2'b00:   req_mis = 1'b0;
            2'b01:   req_mis = req_addr[0];
            2'b10:   req_mis = |req_addr[1:0];
            default: req_mis = 1'b1;
        endcase
    end

    // Little-endian lanes: byte offset selects bits [8*off +: 8].
    always_comb begin
        byte_sel = dm_q[{addr_q[1:0], 3'b000} +: 8];
        half_sel = addr_q[1] ? dm_q[31:16] : dm_q[15:0];
        load_val = dm_q;
        case (size_q)
            2'b00: load_val = uns_q ? {24'd0, byte_sel}
                                    : {{24{byte_sel[7]}}, byte_sel};
            2'b01: load_val = uns_q ? {16'd0, half_sel}
                                    : {{16{half_sel[15]}}, half_sel};
            default: load_val = dm_q;
        endcase
        merge_val = dm_q;
        if (size_q == 2'b00)
            merge_val[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merge_val[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        uns_d   = uns_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mis_d   = mis_q;
        rdata_d = rdata_q;
        merge_d = merge_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    addr_d  = req_addr[AW-1:0];
                    wdata_d = req_wdata;
                    mis_d   = req_mis;
                    rdata_d = 32'd0;
                    if (req_mis)
                        state_d = S_RESP;
                    else if (!req_we)
                        state_d = S_LOAD;
                    else if (req_size == 2'b10)
                        state_d = S_WRITE;
                    else
                        state_d = S_RMW;
                end
            end
            S_LOAD: begin
                rdata_d = load_val;
                state_d = S_RESP;
            end
            S_RMW: begin
                merge_d = merge_val;
                state_d = S_WRITE;
            end
            S_WRITE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            mis_q   <= 1'b0;
            rdata_q <= 32'd0;
            merge_q <= '0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
            rdata_q <= rdata_d;
            merge_q <= merge_d;
        end
    end

    assign req_ready      = (state_q == S_IDLE);
    assign rsp_valid      = (state_q == S_RESP);
    assign rsp_rdata      = rdata_q;
    assign rsp_misaligned = mis_q && (state_q == S_RESP);
    assign dm_we          = (state_q == S_WRITE);
    assign dm_address     = addr_q[AW-1:2];
    assign dm_d           = (size_q == 2'b10) ? wdata_q : merge_q;

endmodule
